machine_timer: RTL
==================

MACHINE_TIMER -- requirements
Module: machine_timer

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_1000: byte base of the 32-byte register window; bits [4:0] ignored.
REQ-002 SHALL have parameter PRESCALE_W, default 16: width of the prescaler counter and PRESCALE register.
REQ-003 SHALL use one clock and a synchronous, active-high reset; port `clock`, input, 1 bit: sole clock, all state updates on its rising edge.
REQ-004 SHALL have port `reset`, input, 1 bit: synchronous active-high reset.
REQ-005 SHALL have port `dmem_rw_addr`, input, 32 bits: CPU data address.
REQ-006 SHALL have port `dmem_w_en`, input, 1 bit: CPU store strobe.
REQ-007 SHALL have port `funct3`, input, 3 bits: CPU access size; 3'b010 = word.
REQ-008 SHALL have port `rs2_data`, input, 32 bits: CPU store data.
REQ-009 SHALL have port `rd_data`, output, 32 bits: read data to the CPU load mux.
REQ-010 SHALL have port `int_req`, output, 1 bit: machine timer interrupt to the CPU.

Function
REQ-011 SHALL decode a hit when dmem_rw_addr[31:5] == BASE_ADDR[31:5]; word offset = dmem_rw_addr[4:2]; dmem_rw_addr[1:0] ignored.
REQ-012 Register map SHALL be: 0x00 MTIME_LO, 0x04 MTIME_HI, 0x08 MTIMECMP_LO, 0x0C MTIMECMP_HI, 0x10 CTRL, 0x14 PRESCALE, 0x18 STATUS, 0x1C reserved.
REQ-013 CTRL SHALL hold bit0 EN (count enable), bit1 IE (interrupt enable), bit2 AR (auto-reload); bits [31:3] read 0.
REQ-014 STATUS SHALL hold bit0 PEND; writing 1 to bit0 clears it, writing 0 has no effect; bits [31:1] read 0.
REQ-015 Reads SHALL be combinational (zero latency): rd_data = addressed register on hit, 32'h0 on miss or reserved offset, independent of funct3.
REQ-016 Writes SHALL occur at the clock edge only when hit && dmem_w_en && funct3 == 3'b010; byte/half stores to the window SHALL be ignored.
REQ-017 Prescaler SHALL count 0..PRESCALE while EN=1 and emit a one-cycle tick when the count equals PRESCALE, then return to 0; PRESCALE=0 SHALL tick every cycle; EN=0 SHALL hold the count.
REQ-018 On a tick, mtime (64-bit) SHALL increment by 1 and wrap from 64'hFFFF_FFFF_FFFF_FFFF to 0.
REQ-019 Match SHALL be EN && (mtime >= mtimecmp), unsigned 64-bit, evaluated on registered values every cycle.
REQ-020 Match SHALL set PEND at the next edge; PEND is sticky until cleared per REQ-014.
REQ-021 With AR=1, a tick while match SHALL load mtime with 0 instead of incrementing.
REQ-022 int_req SHALL equal PEND && IE, driven from registers only (no combinational path from the bus inputs).
REQ-023 A software write to MTIME_LO/MTIME_HI in the same cycle as a tick SHALL win; the written half takes the written value, the other half holds.
REQ-024 A STATUS W1C in the same cycle as a match SHALL leave PEND=1 (set wins).
REQ-025 A write to PRESCALE SHALL also clear the prescaler count to 0.
REQ-026 Writes to MTIMECMP SHALL NOT clear PEND.

Reset
REQ-027 On reset: mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, CTRL=0, PRESCALE=0, prescaler count=0, PEND=0, int_req=0.
REQ-028 rd_data SHALL reflect reset register values combinationally during reset; a store during reset SHALL be ignored.
REQ-029 Reset asserted mid-count SHALL discard any pending tick and match in that cycle.

Configuration
REQ-030 Macro MACHINE_TIMER_PRESCALER_EN defined: the prescaler is present per REQ-017 and REQ-025.
REQ-031 MACHINE_TIMER_PRESCALER_EN undefined: no prescaler logic; the tick is asserted every cycle while EN=1; PRESCALE reads 0 and writes to it are ignored.

Verification
REQ-032 Reset, then read 0x08/0x0C/0x10 -> rd_data 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0; int_req=0.
REQ-033 PRESCALE=3, CMP=10, CTRL=3 -> mtime increments every 4 cycles; PEND=1 one cycle after mtime reaches 10; int_req=1; W1C STATUS -> PEND set again next cycle because match persists.
REQ-034 MTIME=64'hFFFFFFFF_FFFFFFFF, PRESCALE=0, EN=1 -> mtime=0 after one cycle; no match while CMP>0.
REQ-035 AR=1, CMP=5, PRESCALE=0 -> mtime sequence 0,1,2,3,4,5,0,1... ; PEND set; int_req follows IE toggling.
REQ-036 STATUS W1C in the same cycle as first match -> PEND=1; SB (funct3=000) to CTRL -> CTRL unchanged.
REQ-037 Build without MACHINE_TIMER_PRESCALER_EN, write PRESCALE=7, EN=1 -> PRESCALE reads 0; mtime increments every cycle.

Source files
------------

// File: rtl/machine_timer.sv
// Memory-mapped 64-bit machine timer with compare, auto-reload and sticky interrupt pending.
// Optional prescaler is built only when MACHINE_TIMER_PRESCALER_EN is defined.
module machine_timer #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_1000,
  parameter int          PRESCALE_W = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] dmem_rw_addr,
  input  logic        dmem_w_en,
  input  logic [2:0]  funct3,
  input  logic [31:0] rs2_data,
  output logic [31:0] rd_data,
  output logic        int_req
);

  localparam logic [2:0] OFF_MTIME_LO = 3'd0;
  localparam logic [2:0] OFF_MTIME_HI = 3'd1;
  localparam logic [2:0] OFF_CMP_LO   = 3'd2;
  localparam logic [2:0] OFF_CMP_HI   = 3'd3;
  localparam logic [2:0] OFF_CTRL     = 3'd4;
  localparam logic [2:0] OFF_PRESCALE = 3'd5;
  localparam logic [2:0] OFF_STATUS   = 3'd6;

  logic        hit;
  logic [2:0]  offset;
  logic        wr_ok;
  logic [63:0] mtime;
  logic [63:0] mtime_next;
  logic [63:0] mtimecmp;
  logic        en;
  logic        ie;
  logic        ar;
  logic        pend;
  logic        tick;
  logic        match;
  logic        unused_addr_bits;

  assign hit              = (dmem_rw_addr[31:5] == BASE_ADDR[31:5]);
  assign offset           = dmem_rw_addr[4:2];
  assign wr_ok            = hit && dmem_w_en && (funct3 == 3'b010);
  assign unused_addr_bits = ^dmem_rw_addr[1:0];

  assign match   = en && (mtime >= mtimecmp);
  assign int_req = pend && ie;

`ifdef MACHINE_TIMER_PRESCALER_EN
  logic [PRESCALE_W-1:0] prescale;
  logic [PRESCALE_W-1:0] presc_cnt;

  assign tick = en && (presc_cnt == prescale);

  // A PRESCALE write restarts the count so the new period begins cleanly.
  always_ff @(posedge clock) begin
    if (reset) begin
      prescale  <= '0;
      presc_cnt <= '0;
    end else if (wr_ok && (offset == OFF_PRESCALE)) begin
      prescale  <= rs2_data[PRESCALE_W-1:0];
      presc_cnt <= '0;
    end else if (en) begin
      presc_cnt <= tick ? '0 : presc_cnt + PRESCALE_W'(1);
    end
  end
`else
  logic [PRESCALE_W-1:0] prescale;

  assign prescale = '0;
  assign tick     = en;
`endif

  // Software writes override the tick; the unwritten half keeps its old value.
  always_comb begin
    mtime_next = mtime;
    if (tick) begin
      mtime_next = (ar && match) ? 64'd0 : mtime + 64'd1;
    end
    if (wr_ok && (offset == OFF_MTIME_LO)) begin
      mtime_next = {mtime[63:32], rs2_data};
    end
    if (wr_ok && (offset == OFF_MTIME_HI)) begin
      mtime_next = {rs2_data, mtime[31:0]};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      mtime    <= 64'd0;
      mtimecmp <= 64'hFFFF_FFFF_FFFF_FFFF;
      en       <= 1'b0;
      ie       <= 1'b0;
      ar       <= 1'b0;
      pend     <= 1'b0;
    end else begin
      mtime <= mtime_next;
      if (wr_ok && (offset == OFF_CMP_LO)) begin
        mtimecmp[31:0] <= rs2_data;
      end
      if (wr_ok && (offset == OFF_CMP_HI)) begin
        mtimecmp[63:32] <= rs2_data;
      end
      if (wr_ok && (offset == OFF_CTRL)) begin
        en <= rs2_data[0];
        ie <= rs2_data[1];
        ar <= rs2_data[2];
      end
      // Set has priority over a simultaneous write-one-to-clear.
      if (match) begin
        pend <= 1'b1;
      end else if (wr_ok && (offset == OFF_STATUS) && rs2_data[0]) begin
        pend <= 1'b0;
      end
    end
  end

  always_comb begin
    rd_data = 32'h0;
    if (hit) begin
      case (offset)
        OFF_MTIME_LO: rd_data = mtime[31:0];
        OFF_MTIME_HI: rd_data = mtime[63:32];
        OFF_CMP_LO:   rd_data = mtimecmp[31:0];
        OFF_CMP_HI:   rd_data = mtimecmp[63:32];
        OFF_CTRL:     rd_data = {29'd0, ar, ie, en};
        OFF_PRESCALE: rd_data = 32'(prescale);
        OFF_STATUS:   rd_data = {31'd0, pend};
        default:      rd_data = 32'h0;
      endcase
    end
  end

endmodule
